// File: rtl/fpu_arbiter_if.sv
// Bundle of requester, response and shared-FPU signals for fpu_arbiter.
// slave = arbiter side, master = requesters plus FPU side.
interface fpu_arbiter_if;
    logic        req0_valid;
    logic        req1_valid;
    logic [31:0] req0_op_a;
    logic [31:0] req0_op_b;
    logic [31:0] req1_op_a;
    logic [31:0] req1_op_b;
    logic        req0_ready;
    logic        req1_ready;
    logic        rsp0_valid;
    logic        rsp1_valid;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_status;
    logic [31:0] fpu_op_a;
    logic [31:0] fpu_op_b;
    logic [31:0] fpu_data;
    logic [3:0]  fpu_status;
    logic        busy;

    modport slave (
        input  req0_valid, req1_valid, req0_op_a, req0_op_b, req1_op_a, req1_op_b,
        input  fpu_data, fpu_status,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_status,
        output fpu_op_a, fpu_op_b, busy
    );

    modport master (
        output req0_valid, req1_valid, req0_op_a, req0_op_b, req1_op_a, req1_op_b,
        output fpu_data, fpu_status,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data, rsp_status,
        input  fpu_op_a, fpu_op_b, busy
    );
endinterface

// File: rtl/fpu_arbiter.sv
// Two-requester arbiter in front of a shared fixed-latency FPU (IDLE -> WAIT -> RESP).
// Define FPU_ARB_FIXED_PRIO_EN for fixed priority (req0 wins); default is round-robin.
module fpu_arbiter #(
    parameter int unsigned FPU_LATENCY = 8
) (
    input  logic         clock100KHz,
    input  logic         reset,
    fpu_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;
    localparam logic [7:0] LAT_INIT = 8'(FPU_LATENCY);

    logic [1:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        grantee_q, grantee_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [31:0] rsp_data_q, rsp_data_d;
    logic [3:0]  rsp_status_q, rsp_status_d;
    logic        grant_sel;
    logic        accept;

`ifdef FPU_ARB_FIXED_PRIO_EN
    always_comb grant_sel = ~bus.req0_valid;
`else
    logic last_q, last_d;

    // On contention favour whoever was not served last; a lone requester always wins.
    always_comb begin
        if (bus.req0_valid && bus.req1_valid)
            grant_sel = ~last_q;
        else
            grant_sel = ~bus.req0_valid;
    end
`endif

    assign accept = reset && (state_q == ST_IDLE) && (bus.req0_valid || bus.req1_valid);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        grantee_d    = grantee_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        rsp_data_d   = rsp_data_q;
        rsp_status_d = rsp_status_q;
`ifndef FPU_ARB_FIXED_PRIO_EN
        last_d       = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_WAIT;
                    cnt_d     = LAT_INIT;
                    grantee_d = grant_sel;
                    op_a_d    = grant_sel ? bus.req1_op_a : bus.req0_op_a;
                    op_b_d    = grant_sel ? bus.req1_op_b : bus.req0_op_b;
`ifndef FPU_ARB_FIXED_PRIO_EN
                    last_d    = grant_sel;
`endif
                end
            end
            ST_WAIT: begin
                // Saturating decrement; the FPU result is valid on the edge where the count is 1.
                if (cnt_q != 8'd0)
                    cnt_d = cnt_q - 8'd1;
                if (cnt_q <= 8'd1) begin
                    state_d      = ST_RESP;
                    rsp_data_d   = bus.fpu_data;
                    rsp_status_d = bus.fpu_status;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 8'd0;
            grantee_q    <= 1'b0;
            op_a_q       <= 32'd0;
            op_b_q       <= 32'd0;
            rsp_data_q   <= 32'd0;
            rsp_status_q <= 4'd0;
`ifndef FPU_ARB_FIXED_PRIO_EN
            last_q       <= 1'b1;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            grantee_q    <= grantee_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            rsp_data_q   <= rsp_data_d;
            rsp_status_q <= rsp_status_d;
`ifndef FPU_ARB_FIXED_PRIO_EN
            last_q       <= last_d;
`endif
        end
    end

    assign bus.req0_ready = accept && !grant_sel;
    assign bus.req1_ready = accept && grant_sel;
    assign bus.rsp0_valid = (state_q == ST_RESP) && !grantee_q;
    assign bus.rsp1_valid = (state_q == ST_RESP) && grantee_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_status = rsp_status_q;
    assign bus.fpu_op_a   = op_a_q;
    assign bus.fpu_op_b   = op_b_q;
    assign bus.busy       = (state_q != ST_IDLE);
endmodule
